// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the pipelined ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_NOT  = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_NOR  = 4'b0110;
   localparam logic [3:0] OP_SHL  = 4'b0111;
   localparam logic [3:0] OP_SHR  = 4'b1000;
   localparam logic [3:0] OP_ASR  = 4'b1001;
   localparam logic [3:0] OP_ROL  = 4'b1010;
   localparam logic [3:0] OP_ROR  = 4'b1011;
   localparam logic [3:0] OP_EQ   = 4'b1100;
   localparam logic [3:0] OP_MUL  = 4'b1101;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Only present when ALU_PIPE_MUL_EN is defined.
`ifdef ALU_PIPE_MUL_EN
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);

   localparam int CW = $clog2(WIDTH);

   logic               busy;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] accNext;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;

   // The final partial sum is offered combinationally so the result lands
   // on the same edge as the last iteration.
   always_comb begin
      accNext = acc + (mplier[0] ? mcand : '0);
   end

   assign done = busy && (count == CW'(WIDTH - 1));
   assign prod = accNext;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         count  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         count  <= '0;
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
      end else if (busy) begin
         acc    <= accNext;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (done) begin
            busy  <= 1'b0;
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule
`endif

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU behind valid/ready handshakes on both sides.
// Define ALU_PIPE_MUL_EN to build in the iterative multiply on opcode 1101.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ctrl,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry
);

   logic             accept;
   logic             loadNow;
   logic [WIDTH-1:0] loadVal;
   logic             loadCarry;
   logic [WIDTH-1:0] res;
   logic             resCarry;
   logic [WIDTH:0]   sumExt;
   logic [WIDTH:0]   diffExt;

   assign accept = in_valid && in_ready;

   // Sign-extending by one bit makes overflow visible as top-two-bit disagreement.
   always_comb begin
      sumExt   = {x[WIDTH-1], x} + {y[WIDTH-1], y};
      diffExt  = {x[WIDTH-1], x} - {y[WIDTH-1], y};
      res      = '0;
      resCarry = 1'b0;
      case (ctrl)
         OP_ADD: begin
            res      = sumExt[WIDTH-1:0];
            resCarry = sumExt[WIDTH] ^ sumExt[WIDTH-1];
         end
         OP_SUB: begin
            res      = diffExt[WIDTH-1:0];
            resCarry = diffExt[WIDTH] ^ diffExt[WIDTH-1];
         end
         OP_AND:  res = x & y;
         OP_OR:   res = x | y;
         OP_NOT:  res = ~x;
         OP_XOR:  res = x ^ y;
         OP_NOR:  res = ~(x | y);
         OP_SHL:  res = y << x[SHW-1:0];
         OP_SHR:  res = y >> x[SHW-1:0];
         OP_ASR:  res = {x[WIDTH-1], x[WIDTH-1:1]};
         OP_ROL:  res = {x[WIDTH-2:0], x[WIDTH-1]};
         OP_ROR:  res = {x[0], x[WIDTH-1:1]};
         OP_EQ:   res = {{(WIDTH-1){1'b0}}, x == y};
         default: ;
      endcase
   end

`ifdef ALU_PIPE_MUL_EN
   logic [0:0]         state;
   logic               isMul;
   logic               mulStart;
   logic               mulDone;
   logic [2*WIDTH-1:0] mulProd;

   assign isMul    = (ctrl == OP_MUL);
   assign mulStart = accept && isMul;
   assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);

   // The multiplier owns the iteration count; this FSM only gates acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (mulStart) state <= ST_MUL;
            ST_MUL:  if (mulDone)  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   alu_mul_seq #(.WIDTH(WIDTH)) mulUnit (
      .clk   (clk),
      .rst   (rst),
      .start (mulStart),
      .a     (x),
      .b     (y),
      .done  (mulDone),
      .prod  (mulProd)
   );

   assign loadNow   = (accept && !isMul) || mulDone;
   assign loadVal   = mulDone ? mulProd[WIDTH-1:0] : res;
   assign loadCarry = mulDone ? (|mulProd[2*WIDTH-1:WIDTH]) : resCarry;
`else
   assign in_ready  = !out_valid || out_ready;
   assign loadNow   = accept;
   assign loadVal   = res;
   assign loadCarry = resCarry;
`endif

   // A load wins over a drain, so back-to-back results flow without a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
         carry     <= 1'b0;
      end else if (loadNow) begin
         out_valid <= 1'b1;
         out       <= loadVal;
         carry     <= loadCarry;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus random operations
// compared against an integer-arithmetic reference model.
module tb_alu_pipe;

   localparam int WIDTH = 8;

`ifdef ALU_PIPE_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] ctrl;
   logic [7:0] x;
   logic [7:0] y;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic       carry;

   int checks    = 0;
   int passCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ctrl      (ctrl),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .carry     (carry)
   );

   // Reference model: returns {carry, out} using plain integer arithmetic.
   function automatic logic [8:0] refAlu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int s;
      int p;
      case (op)
         4'd0: begin
            s = int'($signed(a)) + int'($signed(b));
            return {(s > 127 || s < -128), 8'(s)};
         end
         4'd1: begin
            s = int'($signed(a)) - int'($signed(b));
            return {(s > 127 || s < -128), 8'(s)};
         end
         4'd2:  return {1'b0, a & b};
         4'd3:  return {1'b0, a | b};
         4'd4:  return {1'b0, ~a};
         4'd5:  return {1'b0, a ^ b};
         4'd6:  return {1'b0, ~(a | b)};
         4'd7:  return {1'b0, 8'(int'(b) << a[2:0])};
         4'd8:  return {1'b0, 8'(int'(b) >> a[2:0])};
         4'd9:  return {1'b0, 8'(int'($signed(a)) / 2 - ((a[7] && a[0]) ? 1 : 0))};
         4'd10: return {1'b0, 8'((int'(a) << 1) | (int'(a) >> 7))};
         4'd11: return {1'b0, 8'((int'(a) >> 1) | (int'(a) << 7))};
         4'd12: return (a == b) ? 9'h001 : 9'h000;
         4'd13: begin
            if (MUL_ON) begin
               p = int'(a) * int'(b);
               return {(p > 255), 8'(p)};
            end
            return 9'h000;
         end
         default: return 9'h000;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Offers one operation, waits (bounded) for acceptance, then scrambles the
   // operand bus so late sampling of ctrl/x/y would be exposed.
   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      ctrl     = op;
      x        = a;
      y        = b;
      for (int i = 0; i < 50 && !in_ready; i++) tick();
      checkOutput("acceptReady", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      ctrl     = 4'($urandom);
      x        = 8'($urandom);
      y        = 8'($urandom);
   endtask

   task automatic runOp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
      logic [8:0] exp;
      int         expLat;
      int         lat;
      exp    = refAlu(op, a, b);
      expLat = (MUL_ON && op == 4'd13) ? WIDTH + 1 : 1;
      applyStimulus(op, a, b);
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      checkOutput({tag, ".lat"}, 32'(lat), 32'(expLat));
      checkOutput({tag, ".out"}, 32'(out), 32'(exp[7:0]));
      checkOutput({tag, ".carry"}, 32'(carry), 32'(exp[8]));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic seen;
      logic [3:0] rop;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ctrl      = 4'd0;
      x         = 8'd0;
      y         = 8'd0;
      repeat (2) tick();
      checkOutput("rstValid", 32'(out_valid), 0);
      checkOutput("rstOut", 32'(out), 0);
      checkOutput("rstCarry", 32'(carry), 0);
      rst = 1'b0;
      #1;
      checkOutput("postRstReady", 32'(in_ready), 1);

      runOp(4'd0, 8'h7F, 8'h01, "add7F01");
      checkOutput("add7F01.value", 32'(out), 32'h80);
      runOp(4'd1, 8'h80, 8'h01, "sub8001");
      runOp(4'd1, 8'h05, 8'h03, "sub0503");
      runOp(4'd7, 8'h0B, 8'h01, "shl3");
      checkOutput("shl3.value", 32'(out), 32'h08);
      runOp(4'd11, 8'h01, 8'h00, "ror01");
      checkOutput("ror01.value", 32'(out), 32'h80);
      runOp(4'd12, 8'h5A, 8'h5A, "eq5A");
      checkOutput("eq5A.value", 32'(out), 32'h01);

      // Backpressure: result must hold while the consumer stalls.
      tick();
      out_ready = 1'b0;
      applyStimulus(4'd5, 8'hF0, 8'hFF);
      checkOutput("bpValid", 32'(out_valid), 1);
      checkOutput("bpOut", 32'(out), 32'h0F);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("bpStallReady", 32'(in_ready), 0);
         checkOutput("bpStallOut", 32'(out), 32'h0F);
         checkOutput("bpStallValid", 32'(out_valid), 1);
      end
      in_valid  = 1'b1;
      ctrl      = 4'd0;
      x         = 8'h01;
      y         = 8'h02;
      out_ready = 1'b1;
      #1;
      checkOutput("bpDrainReady", 32'(in_ready), 1);
      tick();
      checkOutput("bpNextValid", 32'(out_valid), 1);
      checkOutput("bpNextOut", 32'(out), 32'h03);
      ctrl = 4'd3;
      x    = 8'h0C;
      y    = 8'h30;
      tick();
      checkOutput("bpNoBubbleValid", 32'(out_valid), 1);
      checkOutput("bpNoBubbleOut", 32'(out), 32'h3C);
      in_valid = 1'b0;
      tick();

      if (MUL_ON) begin
         applyStimulus(4'd13, 8'd13, 8'd11);
         for (int k = 0; k < WIDTH; k++) begin
            checkOutput("mulBusyReady", 32'(in_ready), 0);
            checkOutput("mulBusyValid", 32'(out_valid), 0);
            tick();
         end
         checkOutput("mul13x11.valid", 32'(out_valid), 1);
         checkOutput("mul13x11.out", 32'(out), 32'h8F);
         checkOutput("mul13x11.carry", 32'(carry), 0);
         runOp(4'd13, 8'd16, 8'd16, "mul16x16");
         runOp(4'd2, 8'hFF, 8'h0F, "andAfterMul");

         // Reset on the fourth MUL cycle must abort without a result.
         applyStimulus(4'd13, 8'h25, 8'h13);
         repeat (3) tick();
         rst = 1'b1;
         tick();
         checkOutput("abortValid", 32'(out_valid), 0);
         checkOutput("abortOut", 32'(out), 0);
         checkOutput("abortCarry", 32'(carry), 0);
         checkOutput("abortReady", 32'(in_ready), 1);
         rst  = 1'b0;
         seen = 1'b0;
         for (int k = 0; k < 20; k++) begin
            seen = seen | out_valid;
            tick();
         end
         checkOutput("abortNoResult", 32'(seen), 0);
      end

      runOp(4'd13, 8'd3, 8'd3, "op1101");
      runOp(4'd15, 8'd3, 8'd3, "op1111");

      for (int n = 0; n < 60; n++) begin
         rop = 4'($urandom_range(0, 15));
         runOp(rop, 8'($urandom), 8'($urandom), $sformatf("rand%0d.op%0d", n, rop));
      end

      tick();
      $display("%0d/%0d checks passed", passCount, checks);
      $finish;
   end

endmodule
